// File: rtl/roi_mask_gen.sv
// roi_mask_gen: NUM_RECT double-buffered ROI rectangles -> 2-stage mask/hit_id/hit_vec pipeline + per-frame hit count (cfg_* in, frame_start/pix_valid/tv_x/tv_y/en in, mask_valid/mask/hit_id/hit_vec/frame_hits/cfg_pending out)
module roi_mask_gen #(
  parameter int NUM_RECT = 8,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int MASK_W   = 11,
  parameter int CNT_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_idx,
  input  logic [2:0]          cfg_field,
  input  logic [15:0]         cfg_data,
  input  logic                cfg_commit,
  output logic                cfg_pending,
  input  logic                frame_start,
  input  logic                pix_valid,
  input  logic [XW-1:0]       tv_x,
  input  logic [YW-1:0]       tv_y,
  input  logic                en,
  output logic                mask_valid,
  output logic [MASK_W-1:0]   mask,
  output logic [3:0]          hit_id,
  output logic [NUM_RECT-1:0] hit_vec,
  output logic [CNT_W-1:0]    frame_hits
);
  typedef struct packed {
    logic              ena;
    logic [MASK_W-1:0] label;
    logic [YW-1:0]     y1;
    logic [YW-1:0]     y0;
    logic [XW-1:0]     x1;
    logic [XW-1:0]     x0;
  } rect_t;
  rect_t               shadow_q [NUM_RECT];
  rect_t               shadow_d [NUM_RECT];
  rect_t               active_q [NUM_RECT];
  rect_t               active_d [NUM_RECT];
  logic [MASK_W-1:0]   lab1_q [NUM_RECT];
  logic [MASK_W-1:0]   lab1_d [NUM_RECT];
  logic [NUM_RECT-1:0] wsel, hit, hv1_q, hv1_d, hv2_q, hv2_d;
  logic                pending_q, pending_d, v1_q, v1_d, v2_q, v2_d;
  logic [MASK_W-1:0]   mask_q, mask_d, pm;
  logic [3:0]          id_q, id_d, pid;
  logic [CNT_W-1:0]    cnt_q, cnt_d, fh_q, fh_d, cnt_inc;
  logic                cfg_data_unused;
  assign cfg_data_unused = ^cfg_data;
  always_comb begin
    pending_d = (pending_q && !frame_start) || cfg_commit;
    for (int i = 0; i < NUM_RECT; i++) begin
      wsel[i]            = cfg_we && cfg_idx == 4'(i);
      shadow_d[i].x0     = wsel[i] && cfg_field == 3'd0 ? cfg_data[XW-1:0]     : shadow_q[i].x0;
      shadow_d[i].x1     = wsel[i] && cfg_field == 3'd1 ? cfg_data[XW-1:0]     : shadow_q[i].x1;
      shadow_d[i].y0     = wsel[i] && cfg_field == 3'd2 ? cfg_data[YW-1:0]     : shadow_q[i].y0;
      shadow_d[i].y1     = wsel[i] && cfg_field == 3'd3 ? cfg_data[YW-1:0]     : shadow_q[i].y1;
      shadow_d[i].label  = wsel[i] && cfg_field == 3'd4 ? cfg_data[MASK_W-1:0] : shadow_q[i].label;
      shadow_d[i].ena    = wsel[i] && cfg_field == 3'd5 ? cfg_data[0]          : shadow_q[i].ena;
      // the copy takes the shadow as held before this edge, so a same-cycle write stays shadow-only
      active_d[i]        = frame_start && pending_q ? shadow_q[i] : active_q[i];
      hit[i]             = active_q[i].ena && tv_x >= active_q[i].x0 && tv_x <= active_q[i].x1 &&
                           tv_y >= active_q[i].y0 && tv_y <= active_q[i].y1;
      lab1_d[i]          = pix_valid ? active_q[i].label : lab1_q[i];
    end
    v1_d  = pix_valid;
    hv1_d = pix_valid ? (en ? hit : '0) : hv1_q;
    pm    = '0;
    pid   = '0;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (hv1_q[i]) begin
        pm  = lab1_q[i];
        pid = 4'(i);
      end
    end
    v2_d    = v1_q;
    mask_d  = v1_q ? pm : mask_q;
    id_d    = v1_q ? pid : id_q;
    hv2_d   = v1_q ? hv1_q : hv2_q;
    cnt_inc = v2_q && |mask_q && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    cnt_d   = frame_start ? '0 : cnt_inc;
    fh_d    = frame_start ? cnt_inc : fh_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        lab1_q[i]   <= '0;
      end
      pending_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      hv1_q     <= '0;
      hv2_q     <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      fh_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        lab1_q[i]   <= lab1_d[i];
      end
      pending_q <= pending_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      hv1_q     <= hv1_d;
      hv2_q     <= hv2_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      fh_q      <= fh_d;
    end
  end
  assign cfg_pending = pending_q;
  assign mask_valid  = v2_q;
  assign mask        = mask_q;
  assign hit_id      = id_q;
  assign hit_vec     = hv2_q;
  assign frame_hits  = fh_q;
endmodule
